random_byte_uart_tx: RTL and testbench

//  Consumer end of the random-byte interface: samples random_Byte while byte_Valid is high, buffers bytes in a small FIFO,
//  and serializes them as UART 8N1 frames for off-chip capture and statistical testing.

---
 rtl/random_byte_uart_tx_pkg.sv | 20 ++
 rtl/random_byte_uart_tx_if.sv | 32 +++
 rtl/random_byte_uart_tx_fifo.sv | 57 +++++
 rtl/random_byte_uart_tx.sv | 157 +++++++++++++++
 tb/tb_random_byte_uart_tx.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/random_byte_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : random_byte_uart_tx_pkg
//  Purpose  : Shared constants for the random-byte UART transmitter:
//             TX state encoding, UART data-bit count, overflow ceiling.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package random_byte_uart_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int         UART_DATA_BITS = 8;
    localparam logic [7:0] OVF_MAX        = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/random_byte_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : random_byte_uart_tx_if
//  Purpose  : Bundles the random-byte input and the UART/status outputs.
//  Ports    : master - drives random_Byte/byte_Valid, observes status
//             slave  - the transmitter (consumes bytes, drives status)
//  Revision : 1.0 - initial release
// ============================================================================
interface random_byte_uart_tx_if
    import random_byte_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
);
    logic [UART_DATA_BITS-1:0]   random_Byte;
    logic                        byte_Valid;
    logic                        uart_Tx;
    logic                        tx_Busy;
    logic                        byte_Sent;
    logic [$clog2(FIFO_DEPTH):0] fifo_Count;
    logic [7:0]                  overflow_Count;

    modport master (
        output random_Byte, byte_Valid,
        input  uart_Tx, tx_Busy, byte_Sent, fifo_Count, overflow_Count
    );

    modport slave (
        input  random_Byte, byte_Valid,
        output uart_Tx, tx_Busy, byte_Sent, fifo_Count, overflow_Count
    );
endinterface
`default_nettype wire

// File: rtl/random_byte_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : random_byte_uart_tx_fifo
//  Purpose  : Synchronous show-ahead FIFO. Pointers carry one extra wrap bit
//             so full/empty are distinguished without a separate counter.
//  Ports    : clk, rst (async, active-high), i_push/i_din, i_pop,
//             o_dout (head), o_full, o_empty, o_count
//  Revision : 1.0 - initial release
// ============================================================================
module random_byte_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_din,
    output logic      [WIDTH-1:0] o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is legal only when the head leaves the same
    // cycle; the head slot is then overwritten after it has been read.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
endmodule
`default_nettype wire

// File: rtl/random_byte_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : random_byte_uart_tx
//  Purpose  : Samples random bytes while byte_Valid is high (one capture per
//             SAMPLE_DIV cycles), buffers them, and sends them as UART 8N1.
//  Ports    : low_Freq_Clk, reset (async, active-high)
//             bus (slave): random_Byte, byte_Valid in; uart_Tx, tx_Busy,
//             byte_Sent, fifo_Count, overflow_Count out
//  Revision : 1.0 - initial release
// ============================================================================
module random_byte_uart_tx
    import random_byte_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SAMPLE_DIV   = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  wire logic            low_Freq_Clk,
    input  wire logic            reset,
    random_byte_uart_tx_if.slave bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int SAMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [SAMP_W-1:0] c_SAMP_LAST = SAMP_W'(SAMPLE_DIV - 1);
    localparam logic [2:0]        c_BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic [SAMP_W-1:0]         r_samp_cnt;
    logic [7:0]                r_ovf;
    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [BAUD_W-1:0]         r_baud;
    logic [BAUD_W-1:0]         w_baud_next;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_next;
    logic [2:0]                r_bit_cnt;
    logic [2:0]                w_bit_next;
    logic                      r_tx;
    logic                      w_tx_next;
    logic                      w_byte_sent;
    logic                      w_baud_last;
    logic                      w_capture;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_drop;
    logic                      w_full;
    logic                      w_empty;
    logic [UART_DATA_BITS-1:0] w_fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    // ---------------- capture divider and overflow counter ----------------
    assign w_capture = bus.byte_Valid && (r_samp_cnt == '0);
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    always_ff @(posedge low_Freq_Clk or posedge reset) begin
        if (reset) begin
            r_samp_cnt <= '0;
            r_ovf      <= '0;
        end else begin
            if (!bus.byte_Valid || r_samp_cnt == c_SAMP_LAST) r_samp_cnt <= '0;
            else                                              r_samp_cnt <= r_samp_cnt + 1'b1;
            if (w_drop && r_ovf != OVF_MAX) r_ovf <= r_ovf + 1'b1;
        end
    end

    random_byte_uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (low_Freq_Clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (bus.random_Byte),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    // ---------------- TX FSM: state register ----------------
    always_ff @(posedge low_Freq_Clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // ---------------- TX FSM: next state ----------------
    assign w_baud_last = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty)                            w_state_next = ST_START;
            ST_START: if (w_baud_last)                         w_state_next = ST_DATA;
            ST_DATA:  if (w_baud_last && r_bit_cnt == c_BIT_LAST) w_state_next = ST_STOP;
            ST_STOP:  if (w_baud_last)                         w_state_next = ST_IDLE;
            default:                                           w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- TX FSM: outputs / datapath next values ----------------
    always_comb begin
        w_pop        = 1'b0;
        w_baud_next  = w_baud_last ? '0 : r_baud + 1'b1;
        w_shift_next = r_shift;
        w_bit_next   = r_bit_cnt;
        w_byte_sent  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    w_shift_next = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_next   = r_bit_cnt + 1'b1;
                end
            end
            ST_STOP: w_byte_sent = w_baud_last;
            default: ;
        endcase

        // The line level is registered from the next state so it changes on
        // the same edge as the state itself.
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge low_Freq_Clk or posedge reset) begin
        if (reset) begin
            r_baud    <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_baud    <= w_baud_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_next;
            r_tx      <= w_tx_next;
        end
    end

    assign bus.uart_Tx        = r_tx;
    assign bus.tx_Busy        = (r_state != ST_IDLE);
    assign bus.byte_Sent      = w_byte_sent;
    assign bus.fifo_Count     = w_fifo_count;
    assign bus.overflow_Count = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_random_byte_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_random_byte_uart_tx
//  Purpose  : Directed self-checking bench. Three transmitter instances
//             (SAMPLE_DIV = 16, 2, 1; CLKS_PER_BIT = 4; FIFO_DEPTH = 8)
//             share clock and reset; a UART receiver decodes one selected
//             line into a byte queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_random_byte_uart_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    random_byte_uart_tx_if #(.FIFO_DEPTH(8)) if16 ();
    random_byte_uart_tx_if #(.FIFO_DEPTH(8)) if2 ();
    random_byte_uart_tx_if #(.FIFO_DEPTH(8)) if1 ();

    random_byte_uart_tx #(.CLKS_PER_BIT(4), .SAMPLE_DIV(16), .FIFO_DEPTH(8))
        u_dut16 (.low_Freq_Clk(clk), .reset(reset), .bus(if16));
    random_byte_uart_tx #(.CLKS_PER_BIT(4), .SAMPLE_DIV(2), .FIFO_DEPTH(8))
        u_dut2  (.low_Freq_Clk(clk), .reset(reset), .bus(if2));
    random_byte_uart_tx #(.CLKS_PER_BIT(4), .SAMPLE_DIV(1), .FIFO_DEPTH(8))
        u_dut1  (.low_Freq_Clk(clk), .reset(reset), .bus(if1));

    int total = 0;
    int bad   = 0;

    // byte_Sent pulse counters and peak FIFO level of the SAMPLE_DIV=2 unit
    int sent16 = 0, sent2 = 0, sent1 = 0;
    int max_cnt2 = 0;
    bit track_max = 1'b0;
    always @(negedge clk) begin
        if (if16.byte_Sent === 1'b1) sent16++;
        if (if2.byte_Sent  === 1'b1) sent2++;
        if (if1.byte_Sent  === 1'b1) sent1++;
        if (track_max && int'(if2.fifo_Count) > max_cnt2) max_cnt2 = int'(if2.fifo_Count);
    end

    // UART receiver: 4 cycles per bit, samples the middle of every bit
    int         mon_sel = 0;
    bit         mon_en  = 1'b0;
    logic       mon_line;
    logic [7:0] rx_q [$];
    int         rx_err = 0;
    assign mon_line = (mon_sel == 0) ? if16.uart_Tx : (mon_sel == 1) ? if2.uart_Tx : if1.uart_Tx;

    initial begin : rx_mon
        logic [7:0] d;
        logic       st;
        forever begin
            @(posedge clk); #2;
            if (mon_en && !reset && mon_line === 1'b0) begin
                repeat (2) @(posedge clk); #2;
                st = mon_line;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk); #2;
                    d[i] = mon_line;
                end
                repeat (4) @(posedge clk); #2;
                if (st !== 1'b0 || mon_line !== 1'b1) rx_err++;
                rx_q.push_back(d);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        if16.byte_Valid = 1'b0; if16.random_Byte = 8'h00;
        if2.byte_Valid  = 1'b0; if2.random_Byte  = 8'h00;
        if1.byte_Valid  = 1'b0; if1.random_Byte  = 8'h00;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        if1.random_Byte = 8'h3C;
        if1.byte_Valid  = 1'b1;
        repeat (12) step();
        if1.byte_Valid  = 1'b0;
        // 12 captures, one popped, FIFO full after the 9th edge, 3 dropped
        total++; if (if1.fifo_Count !== 4'd8) begin bad++; $display("FAIL pre_fifo_count got=%0d want=8", if1.fifo_Count); end
        total++; if (if1.overflow_Count !== 8'd3) begin bad++; $display("FAIL pre_overflow got=%0d want=3", if1.overflow_Count); end
        total++; if (if1.uart_Tx !== 1'b0) begin bad++; $display("FAIL pre_uart_tx got=%b want=0", if1.uart_Tx); end
        total++; if (if1.tx_Busy !== 1'b1) begin bad++; $display("FAIL pre_busy got=%b want=1", if1.tx_Busy); end
        #2 reset = 1'b1;
        #1;
        total++; if (if1.uart_Tx !== 1'b1) begin bad++; $display("FAIL rst_uart_tx got=%b want=1", if1.uart_Tx); end
        total++; if (if1.tx_Busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", if1.tx_Busy); end
        total++; if (if1.fifo_Count !== 4'd0) begin bad++; $display("FAIL rst_fifo_count got=%0d want=0", if1.fifo_Count); end
        total++; if (if1.overflow_Count !== 8'd0) begin bad++; $display("FAIL rst_overflow got=%0d want=0", if1.overflow_Count); end
        total++; if (if1.byte_Sent !== 1'b0) begin bad++; $display("FAIL rst_byte_sent got=%b want=0", if1.byte_Sent); end
        step(); step();
        reset = 1'b0;
        step();
        total++; if (if1.uart_Tx !== 1'b1 || if1.fifo_Count !== 4'd0) begin
            bad++; $display("FAIL post_rst_idle tx=%b count=%0d want tx=1 count=0", if1.uart_Tx, if1.fifo_Count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_frame();
        logic [9:0] frame;
        int s0;
        frame = {1'b1, 8'hA5, 1'b0};
        mon_sel = 0; rx_q.delete(); s0 = sent16;
        if16.random_Byte = 8'hA5;
        if16.byte_Valid  = 1'b1;
        step();
        if16.byte_Valid  = 1'b0;
        total++; if (if16.fifo_Count !== 4'd1 || if16.uart_Tx !== 1'b1) begin
            bad++; $display("FAIL capture_latency count=%0d tx=%b want count=1 tx=1", if16.fifo_Count, if16.uart_Tx);
        end
        step();
        total++; if (if16.tx_Busy !== 1'b1 || if16.fifo_Count !== 4'd0) begin
            bad++; $display("FAIL pop_latency busy=%b count=%0d want busy=1 count=0", if16.tx_Busy, if16.fifo_Count);
        end
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step();
            total++; if (if16.uart_Tx !== frame[k/4]) begin
                bad++; $display("FAIL frame_bit cycle=%0d got=%b want=%b", k, if16.uart_Tx, frame[k/4]);
            end
            total++; if (if16.byte_Sent !== (k == 39)) begin
                bad++; $display("FAIL byte_sent cycle=%0d got=%b want=%b", k, if16.byte_Sent, (k == 39));
            end
        end
        step();
        total++; if (if16.tx_Busy !== 1'b0 || if16.uart_Tx !== 1'b1) begin
            bad++; $display("FAIL frame_end busy=%b tx=%b want busy=0 tx=1", if16.tx_Busy, if16.uart_Tx);
        end
        total++; if (sent16 - s0 !== 1) begin bad++; $display("FAIL sent_pulses got=%0d want=1", sent16 - s0); end
        total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL rx_frames got=%0d want=1", rx_q.size()); end
        else begin
            total++; if (rx_q[0] !== 8'hA5) begin bad++; $display("FAIL rx_data got=%h want=a5", rx_q[0]); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_gap_captures();
        logic [7:0] run_bytes [6];
        int s0;
        run_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        mon_sel = 0; rx_q.delete(); s0 = sent16;
        for (int i = 0; i < 3; i++) begin
            if16.random_Byte = run_bytes[i]; if16.byte_Valid = 1'b1; step();
        end
        if16.byte_Valid = 1'b0; step();
        for (int i = 3; i < 6; i++) begin
            if16.random_Byte = run_bytes[i]; if16.byte_Valid = 1'b1; step();
        end
        if16.byte_Valid = 1'b0;
        for (int i = 0; i < 200 && rx_q.size() < 2; i++) step();
        repeat (90) step();
        total++; if (rx_q.size() !== 2) begin bad++; $display("FAIL gap_frames got=%0d want=2", rx_q.size()); end
        else begin
            total++; if (rx_q[0] !== 8'h11 || rx_q[1] !== 8'h44) begin
                bad++; $display("FAIL gap_data got=%h,%h want=11,44", rx_q[0], rx_q[1]);
            end
        end
        total++; if (sent16 - s0 !== 2) begin bad++; $display("FAIL gap_sent got=%0d want=2", sent16 - s0); end
        total++; if (rx_err !== 0) begin bad++; $display("FAIL gap_framing errors=%0d want=0", rx_err); end
        total++; if (if16.fifo_Count !== 4'd0 || if16.overflow_Count !== 8'd0) begin
            bad++; $display("FAIL gap_idle count=%0d ovf=%0d want 0,0", if16.fifo_Count, if16.overflow_Count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow_stream();
        logic [7:0] exp_q [13];
        int s0, wrong;
        bit done;
        // accepted captures: edges 1..17 (FIFO fill) and 43, 85, 125, 167
        exp_q = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16,
                  8'd42, 8'd84, 8'd124, 8'd166};
        mon_sel = 1; rx_q.delete(); s0 = sent2; max_cnt2 = 0; track_max = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if2.random_Byte = 8'(i); if2.byte_Valid = 1'b1; step();
        end
        if2.byte_Valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            step();
            done = (if2.fifo_Count == 4'd0) && !if2.tx_Busy && (rx_q.size() >= 13);
        end
        repeat (5) step();
        track_max = 1'b0;
        total++; if (!done) begin bad++; $display("FAIL stream_drain timeout count=%0d busy=%b", if2.fifo_Count, if2.tx_Busy); end
        total++; if (if2.overflow_Count !== 8'd87) begin bad++; $display("FAIL stream_overflow got=%0d want=87", if2.overflow_Count); end
        total++; if (sent2 - s0 !== 13) begin bad++; $display("FAIL stream_sent got=%0d want=13", sent2 - s0); end
        total++; if (int'(if2.overflow_Count) + (sent2 - s0) !== 100) begin
            bad++; $display("FAIL stream_conservation got=%0d want=100", int'(if2.overflow_Count) + (sent2 - s0));
        end
        total++; if (max_cnt2 !== 8) begin bad++; $display("FAIL stream_peak_count got=%0d want=8", max_cnt2); end
        total++; if (rx_q.size() !== 13) begin bad++; $display("FAIL stream_rx_frames got=%0d want=13", rx_q.size()); end
        else begin
            wrong = 0;
            for (int i = 0; i < 13; i++) if (rx_q[i] !== exp_q[i]) wrong++;
            total++; if (wrong !== 0) begin bad++; $display("FAIL stream_rx_data wrong_bytes=%0d want=0", wrong); end
        end
        total++; if (rx_err !== 0) begin bad++; $display("FAIL stream_framing errors=%0d want=0", rx_err); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_with_pop();
        int s0, wrong;
        mon_sel = 0; rx_q.delete(); s0 = sent16;
        // nine single-cycle captures: one goes straight to the line, eight fill the FIFO
        for (int k = 0; k < 9; k++) begin
            if16.random_Byte = 8'h50 + 8'(k); if16.byte_Valid = 1'b1; step();
            if16.byte_Valid = 1'b0; step();
        end
        total++; if (if16.fifo_Count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d want=8", if16.fifo_Count); end
        step(); step();
        if16.random_Byte = 8'hDD; if16.byte_Valid = 1'b1; step();
        if16.byte_Valid = 1'b0;
        total++; if (if16.overflow_Count !== 8'd1 || if16.fifo_Count !== 4'd8) begin
            bad++; $display("FAIL drop_when_full ovf=%0d count=%0d want ovf=1 count=8", if16.overflow_Count, if16.fifo_Count);
        end
        repeat (21) step();
        total++; if (if16.tx_Busy !== 1'b0 || if16.fifo_Count !== 4'd8) begin
            bad++; $display("FAIL pop_cycle busy=%b count=%0d want busy=0 count=8", if16.tx_Busy, if16.fifo_Count);
        end
        if16.random_Byte = 8'hEE; if16.byte_Valid = 1'b1; step();
        if16.byte_Valid = 1'b0;
        total++; if (if16.fifo_Count !== 4'd8 || if16.overflow_Count !== 8'd1 || if16.tx_Busy !== 1'b1) begin
            bad++; $display("FAIL push_with_pop count=%0d ovf=%0d busy=%b want 8,1,1",
                            if16.fifo_Count, if16.overflow_Count, if16.tx_Busy);
        end
        for (int i = 0; i < 600 && rx_q.size() < 10; i++) step();
        repeat (50) step();
        total++; if (rx_q.size() !== 10) begin bad++; $display("FAIL full_rx_frames got=%0d want=10", rx_q.size()); end
        else begin
            wrong = 0;
            for (int i = 0; i < 9; i++) if (rx_q[i] !== 8'h50 + 8'(i)) wrong++;
            if (rx_q[9] !== 8'hEE) wrong++;
            total++; if (wrong !== 0) begin bad++; $display("FAIL full_rx_data wrong_bytes=%0d want=0", wrong); end
        end
        total++; if (sent16 - s0 !== 10) begin bad++; $display("FAIL full_sent got=%0d want=10", sent16 - s0); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturate();
        int s0, wrong;
        bit done;
        mon_sel = 2; rx_q.delete(); s0 = sent1;
        if1.random_Byte = 8'h3C; if1.byte_Valid = 1'b1;
        repeat (1000) step();
        total++; if (if1.overflow_Count !== 8'hFF) begin bad++; $display("FAIL sat_mid got=%0d want=255", if1.overflow_Count); end
        repeat (1000) step();
        total++; if (if1.overflow_Count !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%0d want=255", if1.overflow_Count); end
        total++; if (if1.fifo_Count !== 4'd8) begin bad++; $display("FAIL sat_count got=%0d want=8", if1.fifo_Count); end
        if1.byte_Valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            step();
            done = (if1.fifo_Count == 4'd0) && !if1.tx_Busy && (rx_q.size() >= 57);
        end
        repeat (5) step();
        total++; if (!done) begin bad++; $display("FAIL sat_drain timeout count=%0d frames=%0d", if1.fifo_Count, rx_q.size()); end
        // pops at edges 2, 43, ... 1970 while valid (49) plus 8 buffered
        total++; if (sent1 - s0 !== 57) begin bad++; $display("FAIL sat_sent got=%0d want=57", sent1 - s0); end
        total++; if (rx_q.size() !== 57) begin bad++; $display("FAIL sat_rx_frames got=%0d want=57", rx_q.size()); end
        wrong = 0;
        foreach (rx_q[i]) if (rx_q[i] !== 8'h3C) wrong++;
        total++; if (wrong !== 0) begin bad++; $display("FAIL sat_rx_data wrong_bytes=%0d want=0", wrong); end
        total++; if (rx_err !== 0) begin bad++; $display("FAIL sat_framing errors=%0d want=0", rx_err); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        repeat (3) step();
        mon_en = 1'b1;
        test_single_frame();
        test_gap_captures();
        test_overflow_stream();
        test_full_with_pop();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
